// File: rtl/btn_index_encoder.sv
`default_nettype none
// =============================================================================
// Module  : btn_index_encoder
// Brief   : Debounces four colour buttons and encodes one accepted press into
//           a 2-bit index with VALID/ERR strobes. Optional macro BTN_SYNC_EN
//           adds a 2-flop input synchronizer.
// Revision: 1.0 - initial release
// =============================================================================
module btn_index_encoder #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] btn,
  output logic [1:0] sel,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  localparam logic [DEB_W-1:0] c_last = DEB_W'(DEB_CYCLES - 1);

  logic [3:0]       w_btn;
  state_t           r_state, w_state;
  logic [DEB_W-1:0] r_cnt, w_cnt;
  logic [3:0]       r_snap, w_snap;
  logic [1:0]       r_sel, w_sel;
  logic             r_valid, w_valid;
  logic             r_err, w_err;
  logic             r_busy;
  logic [1:0]       w_idx;
  logic             w_onehot;

`ifdef BTN_SYNC_EN
  logic [3:0] r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn = r_sync2;
`else
  assign w_btn = btn;
`endif

  always_comb begin
    w_idx    = 2'd0;
    w_onehot = 1'b1;
    case (r_snap)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_snap  = r_snap;
    w_sel   = r_sel;
    w_valid = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_btn != 4'b0000) begin
          w_cnt = '0;
          if (en) begin
            w_snap  = w_btn;
            w_state = S_DEBOUNCE;
          end else begin
            // A button already down while disabled must be released first.
            w_state = S_WAIT_REL;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!en) begin
          w_cnt   = '0;
          w_state = S_WAIT_REL;
        end else if (w_btn == r_snap) begin
          if (r_cnt == c_last) begin
            w_cnt   = '0;
            w_state = S_WAIT_REL;
            if (w_onehot) begin
              w_sel   = w_idx;
              w_valid = 1'b1;
            end else begin
              w_err = 1'b1;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end else if (w_btn == 4'b0000) begin
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_snap = w_btn;
          w_cnt  = '0;
        end
      end
      S_WAIT_REL: begin
        if (w_btn == 4'b0000) begin
          if (r_cnt == c_last) begin
            w_cnt   = '0;
            w_state = S_IDLE;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt = '0;
        end
      end
      default: begin
        w_cnt   = '0;
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_snap  <= '0;
      r_sel   <= 2'b00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_snap  <= w_snap;
      r_sel   <= w_sel;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_busy  <= (w_state != S_IDLE);
    end
  end

  assign sel   = r_sel;
  assign valid = r_valid;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_btn_index_encoder.sv
`default_nettype none
// =============================================================================
// Module  : tb_btn_index_encoder
// Brief   : Directed scoreboard bench for btn_index_encoder (DEB_CYCLES=4).
// Revision: 1.0 - initial release
// =============================================================================
module tb_btn_index_encoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] btn;
  logic [1:0] sel;
  logic       valid;
  logic       err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  bit done = 1'b0;

  typedef struct {
    bit       is_err;
    bit [1:0] sel;
    int       at_edge;
  } exp_t;

  exp_t sb[$];

  btn_index_encoder #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .btn  (btn),
    .sel  (sel),
    .valid(valid),
    .err  (err),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A stimulus change made now is first sampled on edge edge_n+1; the strobe
  // follows 4 matching samples later and is seen after edge edge_n+5.
  task automatic expect_strobe(input bit is_err, input bit [1:0] s);
    exp_t e;
    e.is_err  = is_err;
    e.sel     = s;
    e.at_edge = edge_n + 5;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!done && (valid || err)) begin
      exp_t e;
      if (valid && err) chk("strobe_exclusive", 1, 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, err, valid}, 0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind_err", int'(err), int'(e.is_err));
        chk("strobe_edge", edge_n, e.at_edge);
        chk("strobe_sel", int'(sel), int'(e.sel));
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    btn = 4'b0101;
    step(1);
    chk("reset_sel", int'(sel), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_busy", int'(busy), 0);
    step(1);
    rst = 1'b0;
    btn = 4'b0000;
    step(2);
    chk("idle_busy", int'(busy), 0);

    // Single press of colour 2
    en  = 1'b1;
    btn = 4'b0100;
    expect_strobe(1'b0, 2'd2);
    step(1);
    chk("press_busy", int'(busy), 1);
    step(9);
    btn = 4'b0000;
    step(3);
    chk("release_busy_held", int'(busy), 1);
    step(1);
    chk("release_busy_drop", int'(busy), 0);
    step(1);

    // Bounce then real press of colour 1
    btn = 4'b0010;
    step(2);
    btn = 4'b0000;
    step(1);
    btn = 4'b0010;
    expect_strobe(1'b0, 2'd1);
    step(8);
    btn = 4'b0000;
    step(4);
    chk("bounce_busy", int'(busy), 0);
    chk("bounce_sel", int'(sel), 1);

    // Multi-button press
    btn = 4'b1001;
    expect_strobe(1'b1, 2'd1);
    step(6);
    btn = 4'b0000;
    step(4);
    chk("multi_sel_kept", int'(sel), 1);
    chk("multi_busy", int'(busy), 0);

    // Held while disabled, then enabled: must not be accepted
    en  = 1'b0;
    btn = 4'b1000;
    step(3);
    en  = 1'b1;
    step(5);
    chk("disabled_busy", int'(busy), 1);
    btn = 4'b0000;
    step(4);
    chk("disabled_rel_busy", int'(busy), 0);
    btn = 4'b1000;
    expect_strobe(1'b0, 2'd3);
    step(6);
    btn = 4'b0000;
    step(4);
    chk("colour3_sel", int'(sel), 3);

    // Reset at edge k+2 of a debounce
    btn = 4'b0001;
    step(2);
    rst = 1'b1;
    step(1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sel", int'(sel), 0);
    chk("midrst_valid", int'(valid), 0);
    rst = 1'b0;
    btn = 4'b0000;
    step(8);
    chk("post_rst_sel", int'(sel), 0);
    chk("post_rst_busy", int'(busy), 0);

    chk("scoreboard_empty", sb.size(), 0);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_index_encoder.md
Name: btn_index_encoder

Overview:
- Player-input side of the Genius datapath. Takes the four raw colour buttons, debounces them, and encodes a single valid press into the 2-bit index that drives the 4:1 selection path.
- Emits a one-cycle VALID strobe per accepted press and an ERR strobe for multi-button presses.
- Waits for a debounced release before it accepts the next press.

Parameters:
- DEB_CYCLES, 4, number of consecutive stable samples required to accept a press or a release. Legal range is 1..2^DEB_W-1.
- DEB_W, 3, width of the debounce counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  presses are accepted only while high (player's turn).
- BTN  input  4  raw buttons, active high; BTN[i] = colour i.
- SEL  output  2  index of the last accepted button; holds its value between presses.
- VALID  output  1  one-cycle strobe; SEL is valid in the same cycle.
- ERR  output  1  one-cycle strobe; a stable multi-button press was rejected.
- BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: SEL=2'b00, VALID=0, ERR=0, BUSY=0, state=IDLE, cnt=0, snap=0.
- RST has priority over all other logic at every edge. Reset mid-debounce or mid-release returns to IDLE and emits no strobe.
- FSM states are IDLE, DEBOUNCE and WAIT_REL.
- IDLE:
  - BTN==0: stay in IDLE.
  - BTN!=0 and EN=1: snap<=BTN, cnt<=0, go to DEBOUNCE. Call this sample edge k.
  - BTN!=0 and EN=0: cnt<=0, go to WAIT_REL. A button held while disabled is never accepted.
- DEBOUNCE:
  - EN=0: cnt<=0, go to WAIT_REL with no strobe.
  - BTN==snap: cnt<=cnt+1.
  - On the edge where the match count reaches DEB_CYCLES (edge k+DEB_CYCLES):
    - snap one-hot: SEL<=index, VALID<=1.
    - otherwise: ERR<=1 and SEL unchanged.
    - In both cases cnt<=0 and go to WAIT_REL.
  - BTN!=snap and BTN==0: go to IDLE (bounce rejected).
  - BTN!=snap and BTN!=0: snap<=BTN, cnt<=0, stay in DEBOUNCE; the timing restarts.
- WAIT_REL:
  - BTN==0: cnt<=cnt+1. When DEB_CYCLES consecutive zero samples have been seen, go to IDLE.
  - BTN!=0: cnt<=0.
  - EN is ignored in this state.
- Latency: VALID/ERR are high in the cycle after edge k+DEB_CYCLES, i.e. DEB_CYCLES edges after the first sample.
- Strobes: VALID and ERR are never high together and are never high for two consecutive cycles.
- Press rate: at most one strobe per press-and-release cycle.
- BUSY is 0 in IDLE and 1 otherwise, registered with the state.
- Index encoding: 0001→00, 0010→01, 0100→10, 1000→11. Any other nonzero snap is an error.

Optional Feature:
- Macro: BTN_SYNC_EN.
- Defined: BTN passes through a 2-flop synchronizer, reset to 0, before the FSM. All response latencies grow by 2 cycles.
- Undefined: the FSM samples BTN directly; the buttons must already be synchronous to CLK.

Test Plan (DEB_CYCLES=4, BTN_SYNC_EN undefined):
- Reset: RST=1 for 2 cycles with BTN=0101 → SEL=00, VALID=0, ERR=0, BUSY=0 after the first reset edge.
- Single press: EN=1, BTN=0100 held 10 cycles, then 0 → exactly one VALID, 4 edges after the first sample, with SEL=10. BUSY drops 4 edges after the release.
- Bounce: BTN=0010 for 2 cycles, 0000 for 1, then 0010 held 8 → one VALID with SEL=01, timed from the second press.
- Multi-press: BTN=1001 held 6 → ERR pulses once, no VALID, SEL keeps its previous value.
- Disabled: EN=0 with BTN=1000 held, then EN=1 while still held → no VALID. Release for 4 cycles, press 1000 again → VALID with SEL=11.
- Reset mid-debounce: BTN=0001, RST=1 at edge k+2 → IDLE, no VALID, SEL=00, BUSY=0.
